// File: rtl/pulse_fsm_decoder.sv
// pulse_fsm_decoder: measures synchronous pulse widths and reports valid/short/long strobes
module pulse_fsm_decoder #(
  parameter int MIN_WIDTH  = 1,
  parameter int MAX_WIDTH  = 4,
  parameter int WIDTH_BITS = $clog2(MAX_WIDTH + 1),
  parameter int COUNT_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pulse,
  output logic                  valid,
  output logic [WIDTH_BITS-1:0] width,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  level,
  output logic [COUNT_BITS-1:0] count
);
  localparam logic [1:0] SYNC = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] LONG = 2'd3;
  localparam logic [WIDTH_BITS-1:0] MINW = WIDTH_BITS'(MIN_WIDTH);
  localparam logic [WIDTH_BITS-1:0] MAXW = WIDTH_BITS'(MAX_WIDTH);
  logic [1:0]            state;
  logic [WIDTH_BITS-1:0] cnt;
  // State walk, width measurement and one-cycle classification strobes
  always_ff @(posedge clock) begin
    valid     <= 1'b0;
    err_short <= 1'b0;
    err_long  <= 1'b0;
    if (reset) begin
      state <= SYNC;
      cnt   <= '0;
      width <= '0;
      level <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        SYNC: if (!pulse) state <= IDLE;
        IDLE: if (pulse) begin
          state <= HIGH;
          cnt   <= WIDTH_BITS'(1);
        end
        HIGH: if (pulse) begin
          if (cnt == MAXW) begin
            err_long <= 1'b1;
            state    <= LONG;
          end else cnt <= cnt + 1'b1;
        end else begin
          state <= IDLE;
          if (cnt >= MINW) begin
            valid <= 1'b1;
            width <= cnt;
            level <= ~level;
            count <= count + 1'b1;
          end else err_short <= 1'b1;
        end
        default: if (!pulse) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pulse_fsm_decoder.sv
// tb_pulse_fsm_decoder: run-length reference model plus directed and random pulse stimulus
module tb_pulse_fsm_decoder;
  logic clock, reset;
  logic [2:0] pin;
  logic v0, v1, v2, s0, s1, s2, l0, l1, l2, lv0, lv1, lv2;
  logic [2:0] w0, w1, w2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  int checks = 0, errors = 0;
  int minw[3] = '{1, 2, 1};
  int cbits[3] = '{8, 8, 2};
  localparam int MAXW = 4;
  int run[3], ew[3], ec[3];
  bit sync[3], ev[3], es[3], el[3], elv[3];
  bit armed = 0;

  pulse_fsm_decoder u0 (.clock(clock), .reset(reset), .pulse(pin[0]), .valid(v0), .width(w0),
    .err_short(s0), .err_long(l0), .level(lv0), .count(c0));
  pulse_fsm_decoder #(.MIN_WIDTH(2)) u1 (.clock(clock), .reset(reset), .pulse(pin[1]), .valid(v1),
    .width(w1), .err_short(s1), .err_long(l1), .level(lv1), .count(c1));
  pulse_fsm_decoder #(.COUNT_BITS(2)) u2 (.clock(clock), .reset(reset), .pulse(pin[2]), .valid(v2),
    .width(w2), .err_short(s2), .err_long(l2), .level(lv2), .count(c2));

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  always @(posedge clock) begin
    if (reset) armed <= 1;
    for (int i = 0; i < 3; i++) begin
      ev[i] = 0; es[i] = 0; el[i] = 0;
      if (reset) begin
        sync[i] = 1; run[i] = 0; ew[i] = 0; elv[i] = 0; ec[i] = 0;
      end else if (sync[i]) begin
        if (!pin[i]) sync[i] = 0;
      end else if (pin[i]) begin
        run[i]++;
        if (run[i] == MAXW + 1) el[i] = 1;
      end else begin
        if (run[i] >= 1 && run[i] <= MAXW) begin
          if (run[i] >= minw[i]) begin
            ev[i] = 1; ew[i] = run[i]; elv[i] = ~elv[i];
            ec[i] = (ec[i] + 1) % (1 << cbits[i]);
          end else es[i] = 1;
        end
        run[i] = 0;
      end
    end
  end

  always @(negedge clock) if (armed) begin
    chk("valid0", v0, ev[0]); chk("width0", w0, ew[0]); chk("short0", s0, es[0]);
    chk("long0", l0, el[0]); chk("level0", lv0, elv[0]); chk("count0", c0, ec[0]);
    chk("valid1", v1, ev[1]); chk("width1", w1, ew[1]); chk("short1", s1, es[1]);
    chk("long1", l1, el[1]); chk("level1", lv1, elv[1]); chk("count1", c1, ec[1]);
    chk("valid2", v2, ev[2]); chk("width2", w2, ew[2]); chk("short2", s2, es[2]);
    chk("long2", l2, el[2]); chk("level2", lv2, elv[2]); chk("count2", c2, ec[2]);
  end

  initial begin
    int wrap[5] = '{1, 2, 3, 0, 1};
    pin = 3'b000;
    reset = 1;
    cyc(); cyc();
    reset = 0;
    cyc(); cyc();
    pin[0] = 1; cyc(); cyc(); pin[0] = 0; cyc();
    chk("d_valid_2", v0, 1); chk("d_width_2", w0, 2); chk("d_level_2", lv0, 1); chk("d_count_2", c0, 1);
    cyc();
    chk("d_valid_one_cycle", v0, 0);
    pin[1] = 1; cyc(); pin[1] = 0; cyc();
    chk("d_short", s1, 1); chk("d_short_count", c1, 0); chk("d_short_width", w1, 0); chk("d_short_valid", v1, 0);
    pin[1] = 1; cyc(); cyc(); pin[1] = 0; cyc();
    chk("d_min2_valid", v1, 1); chk("d_min2_width", w1, 2);
    cyc();
    pin[0] = 1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 4) chk("d_long_early", l0, 0);
      if (i == 5) chk("d_long", l0, 1);
      if (i == 6) chk("d_long_one_cycle", l0, 0);
    end
    pin[0] = 0; cyc();
    chk("d_long_novalid", v0, 0); chk("d_long_count", c0, 1);
    pin[0] = 1; cyc(); cyc(); cyc(); cyc(); pin[0] = 0; cyc();
    chk("d_w4_valid", v0, 1); chk("d_w4_width", w0, 4); chk("d_w4_count", c0, 2);
    cyc();
    pin[0] = 1; cyc(); reset = 1; cyc(); reset = 0;
    chk("d_rst_count", c0, 0); chk("d_rst_level", lv0, 0); chk("d_rst_width", w0, 0); chk("d_rst_valid", v0, 0);
    cyc(); cyc();
    chk("d_sync_valid", v0, 0);
    pin[0] = 0; cyc(); cyc();
    chk("d_sync_novalid", v0, 0);
    pin[0] = 1; cyc(); pin[0] = 0; cyc();
    chk("d_after_valid", v0, 1); chk("d_after_width", w0, 1); chk("d_after_count", c0, 1);
    for (int i = 0; i < 5; i++) begin
      pin[2] = 1; cyc(); pin[2] = 0; cyc();
      chk("d_wrap_count", c2, wrap[i]);
    end
    chk("d_wrap_level", lv2, 1);
    pin[0] = 1; cyc(); pin[0] = 0; cyc(); pin[0] = 1; cyc(); cyc(); cyc(); pin[0] = 0; cyc();
    chk("d_b2b_width3", w0, 3); chk("d_b2b_level", lv0, 1);
    pin[0] = 1; cyc(); pin[0] = 0; cyc();
    chk("d_b2b_width1", w0, 1); chk("d_b2b_count", c0, 4);
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 2) == 0) pin[i] = ~pin[i];
      reset = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 0;
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_fsm_decoder.md
Name: pulse_fsm_decoder

Overview:
- Receiving end of the pulse protocol: accepts single-bit pulses on a synchronous line and measures each pulse's width in clock cycles.
- Classifies each pulse as valid, short or long and reports it with one-cycle strobes.
- Keeps a wrapping count of valid pulses and a toggle level that reconstructs the edge stream that produced the pulses.
- Sits downstream of pulse generators, on the same clock domain.

Parameters:
- MIN_WIDTH, 1, minimum accepted pulse width in cycles; must be >= 1.
- MAX_WIDTH, 4, maximum accepted pulse width in cycles; must be >= MIN_WIDTH.
- WIDTH_BITS, $clog2(MAX_WIDTH+1), width of the measured-width output and internal counter.
- COUNT_BITS, 8, width of the valid-pulse counter.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- pulse  input  1  incoming pulse line, already synchronous to clock
- valid  output  1  one-cycle strobe: pulse with width in [MIN_WIDTH, MAX_WIDTH] completed
- width  output  WIDTH_BITS  width of the last completed valid pulse; holds between strobes
- err_short  output  1  one-cycle strobe: pulse ended with width < MIN_WIDTH
- err_long  output  1  one-cycle strobe: pulse exceeded MAX_WIDTH
- level  output  1  toggles on every valid strobe
- count  output  COUNT_BITS  number of valid pulses, wraps modulo 2^COUNT_BITS

Behaviour:
- Single clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - state = SYNC, internal counter = 0
  - valid = 0, err_short = 0, err_long = 0
  - width = 0, level = 0, count = 0
- States: SYNC, IDLE, HIGH, LONG. All transitions are evaluated on pulse sampled at the rising edge.
- SYNC: discards a pulse already in progress when reset releases.
  - pulse=1: stay in SYNC, no strobes.
  - pulse=0: go to IDLE.
- IDLE:
  - pulse=1: go to HIGH, counter = 1.
  - pulse=0: stay in IDLE.
- HIGH, pulse=1:
  - counter < MAX_WIDTH: counter + 1, stay in HIGH.
  - counter == MAX_WIDTH: err_long = 1 for the following cycle, go to LONG.
- HIGH, pulse=0:
  - counter >= MIN_WIDTH: valid = 1, width = counter, level inverts, count + 1 (wraps).
  - counter < MIN_WIDTH: err_short = 1; width, level and count unchanged.
  - Either way, go to IDLE.
- LONG:
  - pulse=1: stay in LONG; no further strobes, no count.
  - pulse=0: go to IDLE.
- Timing for a pulse sampled high at edges k..k+N-1 and low at edge k+N:
  - The strobe is high in the cycle after edge k+N.
  - If N > MAX_WIDTH, err_long is instead high in the cycle after edge k+MAX_WIDTH, and nothing is reported at pulse end.
- Strobes are mutually exclusive and last exactly one cycle. All strobes default to 0 each cycle.
- Back-to-back pulses: one low sample is sufficient. From IDLE, a rising pulse on the edge after the low sample is accepted, so the minimum period is N+1 cycles.
- The counter never exceeds MAX_WIDTH, so it cannot overflow WIDTH_BITS.
- Reset asserted mid-pulse or in any state:
  - Aborts the measurement with no strobe.
  - All outputs return to reset values on that edge.
  - If pulse remains high after reset deasserts, it is ignored via SYNC.
- Reset has priority over all other events.

Test Plan:
- Defaults. Reset, then a 2-cycle pulse -> valid high for 1 cycle, 1 cycle after the falling sample; width=2, level=1, count=1.
- MIN_WIDTH=2. A 1-cycle pulse -> err_short for 1 cycle; width, level and count unchanged. A following 2-cycle pulse -> valid, width=2.
- Defaults. An 8-cycle pulse -> err_long for 1 cycle, 4 cycles after the first high sample. No valid at the falling edge; count unchanged. A following 4-cycle pulse -> valid, width=4.
- Defaults. Pulses of widths 1, 3, 1 separated by single low cycles -> three valid strobes, widths 1, 3, 1; level sequence 1, 0, 1; count=3.
- Reset asserted on the 2nd high cycle of a 4-cycle pulse, released while pulse is still high -> no strobes for that pulse, outputs at reset values. The next 1-cycle pulse -> valid, width=1, count=1.
- COUNT_BITS=2. Five valid 1-cycle pulses -> count sequence 1, 2, 3, 0, 1; level ends at 1.
